pipeline_hazard_ctrl: RTL and testbench

- Central sequencing unit for the 5-stage pipeline.
- Drives the write_en/clear pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Resolves load-use stalls, MEM-stage control-transfer flushes (branch/call/ret), multi-cycle data-memory waits and program halt (run=0 reaching WB).
- Keeps saturating performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing unit for the 5-stage pipeline: drives every pipeline
// register's write_en/clear pair and the PC enable, and keeps saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_Rs,
  input  logic [REG_ADDR_W-1:0] id_Rt,
  input  logic                  id_uses_Rs,
  input  logic                  id_uses_Rt,
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_Rd,
  input  logic                  mem_redirect,
  input  logic                  mem_busy,
  input  logic                  wb_run,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_write_en,
  output logic                  ex_mem_write_en,
  output logic                  mem_wb_write_en,
  output logic                  if_id_clear,
  output logic                  id_ex_clear,
  output logic                  ex_mem_clear,
  output logic                  mem_wb_clear,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      freeze_cnt
);

  typedef enum logic [1:0] {INIT, RUN, HALTED} state_t;
  typedef enum logic [2:0] {
    ACT_IDLE, ACT_HALT, ACT_FREEZE, ACT_FLUSH, ACT_STALL, ACT_NORMAL
  } action_t;

  state_t  state;
  state_t  state_next;
  action_t action;
  logic    load_use;

  // Index 0 is an ordinary register here, so no zero-register exemption.
  assign load_use = ex_MemRead &&
                    ((id_uses_Rs && (id_Rs == ex_Rd)) ||
                     (id_uses_Rt && (id_Rt == ex_Rd)));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    action          = ACT_IDLE;
    pc_write_en     = 1'b0;
    if_id_write_en  = 1'b0;
    id_ex_write_en  = 1'b0;
    ex_mem_write_en = 1'b0;
    mem_wb_write_en = 1'b0;
    if_id_clear     = 1'b0;
    id_ex_clear     = 1'b0;
    ex_mem_clear    = 1'b0;
    mem_wb_clear    = 1'b0;
    halted          = 1'b0;

    case (state)
      INIT: begin
        if_id_clear  = 1'b1;
        id_ex_clear  = 1'b1;
        ex_mem_clear = 1'b1;
        mem_wb_clear = 1'b1;
        state_next   = RUN;
      end

      RUN: begin
        if (!wb_run) begin
          action     = ACT_HALT;
          state_next = HALTED;
        end else if (mem_busy) begin
          action = ACT_FREEZE;
        end else if (mem_redirect) begin
          // MEM/WB keeps loading so the transferring instruction still retires.
          action          = ACT_FLUSH;
          pc_write_en     = 1'b1;
          if_id_write_en  = 1'b1;
          id_ex_write_en  = 1'b1;
          ex_mem_write_en = 1'b1;
          mem_wb_write_en = 1'b1;
          if_id_clear     = 1'b1;
          id_ex_clear     = 1'b1;
          ex_mem_clear    = 1'b1;
        end else if (load_use) begin
          action          = ACT_STALL;
          id_ex_write_en  = 1'b1;
          id_ex_clear     = 1'b1;
          ex_mem_write_en = 1'b1;
          mem_wb_write_en = 1'b1;
        end else begin
          action          = ACT_NORMAL;
          pc_write_en     = 1'b1;
          if_id_write_en  = 1'b1;
          id_ex_write_en  = 1'b1;
          ex_mem_write_en = 1'b1;
          mem_wb_write_en = 1'b1;
        end
      end

      HALTED: halted = 1'b1;

      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (action == ACT_STALL)  stall_cnt  <= sat_inc(stall_cnt);
      if (action == ACT_FLUSH)  flush_cnt  <= sat_inc(flush_cnt);
      if (action == ACT_FREEZE) freeze_cnt <= sat_inc(freeze_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a reference model pushes the expected
// enables/clears and next counter values per cycle; a drain task pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int ST_INIT = 0, ST_RUN = 1, ST_HALTED = 2;

  typedef struct {
    logic [9:0]  outs;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [15:0] freeze;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_Rs, id_Rt, ex_Rd;
  logic        id_uses_Rs, id_uses_Rt, ex_MemRead, mem_redirect, mem_busy, wb_run;
  logic        pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic        if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear, halted;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  exp_t        sb[$];
  int          m_state;
  logic [15:0] m_stall, m_flush, m_freeze;
  int          total = 0;
  int          bad = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_Rs(id_uses_Rs), .id_uses_Rt(id_uses_Rt),
    .ex_MemRead(ex_MemRead), .ex_Rd(ex_Rd), .mem_redirect(mem_redirect),
    .mem_busy(mem_busy), .wb_run(wb_run),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
    .mem_wb_write_en(mem_wb_write_en), .if_id_clear(if_id_clear),
    .id_ex_clear(id_ex_clear), .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  // {pc, we if/id/ex/mem, clr if/id/ex/mem, halted}
  function automatic logic [9:0] dutOuts();
    return {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en,
            if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear, halted};
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%h expected=%h", tag, $time, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_state  = ST_INIT;
    m_stall  = '0;
    m_flush  = '0;
    m_freeze = '0;
  endtask

  task automatic applyStimulus(input logic [3:0] rs, input logic [3:0] rt, input logic urs,
                               input logic urt, input logic mr, input logic [3:0] rd,
                               input logic redir, input logic busy, input logic run);
    exp_t e;
    logic lu;
    id_Rs = rs; id_Rt = rt; id_uses_Rs = urs; id_uses_Rt = urt;
    ex_MemRead = mr; ex_Rd = rd; mem_redirect = redir; mem_busy = busy; wb_run = run;
    lu = mr && ((urs && (rs == rd)) || (urt && (rt == rd)));
    if (m_state == ST_INIT) begin
      e.outs = 10'b0_0000_1111_0;
      m_state = ST_RUN;
    end else if (m_state == ST_HALTED) begin
      e.outs = 10'b0_0000_0000_1;
    end else if (!run) begin
      e.outs = 10'b0_0000_0000_0;
      m_state = ST_HALTED;
    end else if (busy) begin
      e.outs = 10'b0_0000_0000_0;
      m_freeze = satInc(m_freeze);
    end else if (redir) begin
      e.outs = 10'b1_1111_1110_0;
      m_flush = satInc(m_flush);
    end else if (lu) begin
      e.outs = 10'b0_0111_0100_0;
      m_stall = satInc(m_stall);
    end else begin
      e.outs = 10'b1_1111_0000_0;
    end
    e.stall = m_stall; e.flush = m_flush; e.freeze = m_freeze;
    sb.push_back(e);
  endtask

  // Combinational outputs are checked mid-cycle, counters just after the edge.
  task automatic drainScoreboard(input string tag);
    exp_t e;
    #2;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_outs"}, {22'd0, dutOuts()}, {22'd0, e.outs});
      @(posedge clk); #1;
      checkOutput({tag, "_stall_cnt"}, {16'd0, stall_cnt}, {16'd0, e.stall});
      checkOutput({tag, "_flush_cnt"}, {16'd0, flush_cnt}, {16'd0, e.flush});
      checkOutput({tag, "_freeze_cnt"}, {16'd0, freeze_cnt}, {16'd0, e.freeze});
    end
  endtask

  task automatic cycle(input string tag, input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt, input logic mr, input logic [3:0] rd,
                       input logic redir, input logic busy, input logic run);
    applyStimulus(rs, rt, urs, urt, mr, rd, redir, busy, run);
    drainScoreboard(tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_outs"}, {22'd0, dutOuts()}, {22'd0, 10'b0_0000_1111_0});
    checkOutput({tag, "_cnts"}, {16'd0, stall_cnt | flush_cnt | freeze_cnt}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    id_Rs = '0; id_Rt = '0; id_uses_Rs = 0; id_uses_Rt = 0;
    ex_MemRead = 0; ex_Rd = '0; mem_redirect = 0; mem_busy = 0; wb_run = 1;
    modelReset();
    #12;
    checkResetState("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    cycle("init",   4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
    cycle("normal", 4'd1, 4'd2, 1, 1, 0, 4'd3, 0, 0, 1);
    cycle("lu_rt",  4'd1, 4'd5, 0, 1, 1, 4'd5, 0, 0, 1);
    cycle("lu_off", 4'd1, 4'd5, 0, 0, 1, 4'd5, 0, 0, 1);
    cycle("lu_rs0", 4'd0, 4'd7, 1, 0, 1, 4'd0, 0, 0, 1);
    cycle("no_ld",  4'd5, 4'd5, 1, 1, 0, 4'd5, 0, 0, 1);
    cycle("flush_lu", 4'd5, 4'd5, 1, 1, 1, 4'd5, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      cycle("freeze_redir", 4'd2, 4'd2, 1, 1, 1, 4'd2, 1, 1, 1);
    cycle("redir_after", 4'd2, 4'd2, 1, 1, 1, 4'd2, 1, 0, 1);

    for (int i = 0; i < 60; i++)
      cycle("rand", 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b1);

    cycle("halt", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cycle("halted", 4'd5, 4'd5, 1, 1, 1, 4'd5, 1, 1'(i), 1);

    rst_n = 1'b0;
    modelReset();
    #1;
    checkResetState("mid_reset");
    checkOutput("mid_reset_halted", {31'd0, halted}, 32'd0);
    #3;
    rst_n = 1'b1;
    cycle("reinit", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);

    for (int i = 0; i < 65539; i++)
      cycle("sat", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1);
    checkOutput("sat_final", {16'd0, freeze_cnt}, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
